// File: rtl/seq_detector_param.sv
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Runtime-loadable serial pattern detector (1..MAX_LEN bits) with
//             input qualifier, overlap select and registered match pulse.
//             Optional saturating match counter under SEQ_DET_COUNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 DEF_LEN     = 3,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
    parameter logic               DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               inp,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               outp,
    output logic               cfg_err
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1 ||
        LEN_W < $clog2(MAX_LEN + 1) || DEF_LEN < 1 || DEF_LEN > MAX_LEN) begin : g_param_check
        $error("seq_detector_param: illegal parameter combination");
    end

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    state_t             r_state;

    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W:0]     w_fill_p1;
    logic [LEN_W-1:0]   w_fill_inc;
    logic               w_reach_len;
    logic               w_match;
    logic               w_cfg_ok;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hist_next = {r_hist[MAX_LEN-2:0], inp};
    assign w_fill_p1   = {1'b0, r_fill} + (LEN_W + 1)'(1);
    assign w_fill_inc  = (r_fill == c_max_len) ? r_fill : r_fill + LEN_W'(1);
    assign w_reach_len = (w_fill_p1 >= {1'b0, r_len});
    // ARMED covers steady-state compares; w_reach_len covers the bit that completes FILL
    assign w_match     = ((r_state == ST_ARMED) || w_reach_len) &&
                         (((w_hist_next ^ r_pattern) & w_mask) == '0);
    assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= c_max_len);

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_count;
    assign match_count = r_count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= ST_FILL;
            outp      <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
            r_count   <= '0;
`endif
        end else begin
            outp    <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_load && w_cfg_ok) begin
                // Accepted load discards the same-cycle sample and any pending pulse
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
                r_state   <= ST_FILL;
`ifdef SEQ_DET_COUNT_EN
                r_count   <= '0;
`endif
            end else begin
                if (cfg_load) begin
                    cfg_err <= 1'b1;
                end
                if (in_valid) begin
                    r_hist <= w_hist_next;
                    outp   <= w_match;
                    if (w_match && !r_overlap) begin
                        r_fill  <= '0;
                        r_state <= ST_FILL;
                    end else begin
                        r_fill  <= w_fill_inc;
                        r_state <= w_reach_len ? ST_ARMED : ST_FILL;
                    end
`ifdef SEQ_DET_COUNT_EN
                    if (w_match && (r_count != '1)) begin
                        r_count <= r_count + CNT_W'(1);
                    end
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Directed scoreboard bench for seq_detector_param (default params).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               inp;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               outp;
    logic               cfg_err;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0]   match_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic  o;
        logic  e;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .inp         (inp),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .outp        (outp),
        .cfg_err     (cfg_err)
`ifdef SEQ_DET_COUNT_EN
        ,
        .match_count (match_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One clock of stimulus; the expected registered outputs for this cycle
    // are queued on drive and compared just after the edge.
    task automatic step(input logic r, input logic v, input logic b, input logic ld,
                        input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ov, input logic eo, input logic ee, input string tag);
        exp_t x;
        exp_t y;
        rst         = r;
        in_valid    = v;
        inp         = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        x.o = eo;
        x.e = ee;
        x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        y = exp_q.pop_front();
        checks++;
        assert (outp === y.o) else begin
            errors++;
            $error("FAIL %s outp: got %b want %b", y.tag, outp, y.o);
        end
        checks++;
        assert (cfg_err === y.e) else begin
            errors++;
            $error("FAIL %s cfg_err: got %b want %b", y.tag, cfg_err, y.e);
        end
    endtask

    task automatic bit_in(input logic v, input logic b, input logic eo, input string tag);
        step(1'b0, v, b, 1'b0, 8'h00, 4'd0, 1'b0, eo, 1'b0, tag);
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic ov, input logic v, input logic b,
                       input logic ee, input string tag);
        step(1'b0, v, b, 1'b1, pat, len, ov, 1'b0, ee, tag);
    endtask

    task automatic chk_cnt(input int want, input string tag);
`ifdef SEQ_DET_COUNT_EN
        checks++;
        assert (int'(match_count) === want) else begin
            errors++;
            $error("FAIL %s match_count: got %0d want %0d", tag, match_count, want);
        end
`else
        if (want < 0) $display("unused %s", tag);
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; inp = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // reset overrides a simultaneous illegal load and valid sample
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, "reset0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "reset1");
        chk_cnt(0, "reset");

        // defaults: 101, len 3, overlapping
        bit_in(1, 1, 0, "ov_b1");
        bit_in(1, 0, 0, "ov_b2");
        bit_in(1, 1, 1, "ov_b3");
        bit_in(1, 0, 0, "ov_b4");
        bit_in(1, 1, 1, "ov_b5");
        chk_cnt(2, "ov");

        // non-overlapping 101
        cfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "nov_cfg");
        chk_cnt(0, "nov_cfg");
        bit_in(1, 1, 0, "nov_b1");
        bit_in(1, 0, 0, "nov_b2");
        bit_in(1, 1, 1, "nov_b3");
        bit_in(1, 0, 0, "nov_b4");
        bit_in(1, 1, 0, "nov_b5");
        bit_in(1, 1, 0, "nov_b6");
        bit_in(1, 0, 0, "nov_b7");
        bit_in(1, 1, 1, "nov_b8");
        chk_cnt(2, "nov");

        // qualifier gaps with pattern 11; inp toggles in gaps but must be ignored
        cfg(8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, "gap_cfg");
        bit_in(1, 1, 0, "gap_v1");
        bit_in(0, 0, 0, "gap_i1");
        bit_in(0, 1, 0, "gap_i2");
        bit_in(0, 0, 0, "gap_i3");
        bit_in(1, 1, 1, "gap_v2");
        bit_in(0, 1, 0, "gap_after");

        // max length A5 = 1010_0101, first-received bit is bit 7
        cfg(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, "max_cfg");
        bit_in(1, 1, 0, "max_b1");
        bit_in(1, 0, 0, "max_b2");
        bit_in(1, 1, 0, "max_b3");
        bit_in(1, 0, 0, "max_b4");
        bit_in(1, 0, 0, "max_b5");
        bit_in(1, 1, 0, "max_b6");
        bit_in(1, 0, 0, "max_b7");
        bit_in(1, 1, 1, "max_b8");
        // pattern self-aligns after a further 5 bits (suffix 101 == prefix 101)
        bit_in(1, 0, 0, "max_r1");
        bit_in(1, 0, 0, "max_r2");
        bit_in(1, 1, 0, "max_r3");
        bit_in(1, 0, 0, "max_r4");
        bit_in(1, 1, 1, "max_r5");
        chk_cnt(2, "max");

        // illegal lengths: rejected, same-cycle samples still shifted in
        cfg(8'hFF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, "ill_len0");
        cfg(8'h00, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, "ill_len9");
        bit_in(1, 1, 0, "ill_b3");
        cfg(8'h00, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, "ill_len15");
        bit_in(1, 1, 1, "ill_b5");
        chk_cnt(3, "ill");

        // len 1 in non-overlap mode still matches consecutive bits
        cfg(8'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "len1_cfg");
        bit_in(1, 1, 1, "len1_b1");
        bit_in(1, 1, 1, "len1_b2");
        bit_in(1, 0, 0, "len1_b3");
        bit_in(1, 1, 1, "len1_b4");
        bit_in(0, 1, 0, "len1_gap");
        chk_cnt(3, "len1");

        // cfg_load on a would-be completing bit: sample discarded, history cleared
        cfg(8'b011, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "mid_cfg1");
        bit_in(1, 0, 0, "mid_b1");
        bit_in(1, 1, 0, "mid_b2");
        cfg(8'b011, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, "mid_cfg2");
        bit_in(1, 1, 0, "mid_b3");
        bit_in(1, 0, 0, "mid_b4");
        bit_in(1, 1, 0, "mid_b5");
        bit_in(1, 1, 1, "mid_b6");
        chk_cnt(1, "mid");

        // reset while a match is due: pulse suppressed, defaults restored
        bit_in(1, 0, 0, "rst_b1");
        bit_in(1, 1, 0, "rst_b2");
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "rst_due");
        chk_cnt(0, "rst_due");
        bit_in(1, 1, 0, "def_b1");
        bit_in(1, 0, 0, "def_b2");
        bit_in(1, 1, 1, "def_b3");
        bit_in(1, 0, 0, "def_b4");
        bit_in(1, 1, 1, "def_b5");
        chk_cnt(2, "def");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector, the successor to the team's fixed 2-bit state detector.
- Runtime-loadable pattern of 1..MAX_LEN bits, input qualifier, and selectable overlapping/non-overlapping matching.
- Produces a registered one-cycle match pulse; sits on serial control/data lines feeding status logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of length fields; must hold MAX_LEN, i.e. >= $clog2(MAX_LEN+1).
- DEF_LEN, 3: pattern length after reset.
- DEF_PATTERN, 8'b0000_0101: pattern after reset; bits above DEF_LEN-1 ignored.
- DEF_OVERLAP, 1: overlap mode after reset (1 = overlapping).
- CNT_W, 16: match counter width (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  sample qualifier; inp consumed only when 1.
- inp  in  1  serial input bit.
- cfg_load  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  new pattern; bit 0 = most recent bit, bit len-1 = first-received bit.
- cfg_len  in  LEN_W  new length, legal 1..MAX_LEN.
- cfg_overlap  in  1  new overlap mode.
- outp  out  1  match pulse, one cycle.
- cfg_err  out  1  pulse, illegal cfg_len rejected.
- match_count  out  CNT_W  saturating match count (only with SEQ_DET_COUNT_EN).

Behaviour:
- Reset (rst=1 at posedge): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, history=0, fill=0, state=FILL, outp=0, cfg_err=0, match_count=0. rst overrides all other inputs.
- History: MAX_LEN shift register. On in_valid=1: history <= {history[MAX_LEN-2:0], inp}. fill counts accepted bits since last clear, saturating at MAX_LEN.
- States:
  - FILL: fill < len. Compare disabled. Moves to ARMED when the accepted bit makes fill reach len.
  - ARMED: compares on each accepted bit.
- Match condition: accepted bit at cycle N where (next history masked to low len bits) == (pattern masked to low len bits) and (fill+1) >= len. Includes the bit that completes FILL.
- Match timing: outp=1 in cycle N+1 only (latency 1). outp=0 in any cycle following a cycle with in_valid=0.
- Overlap=1: history and fill are kept after a match. Example: pattern 101 on stream 10101 gives 2 matches.
- Overlap=0: on match, fill<=0 and state<=FILL; history bits are still shifted but no longer count. Example: 10101 gives 1 match.
- in_valid=0: no state, history or fill change.
- cfg_load=1 with 1 <= cfg_len <= MAX_LEN:
  - Pattern, len and overlap are updated; history and fill cleared; state=FILL; outp=0 next cycle.
  - Any in_valid sample in the same cycle is discarded.
- cfg_load=1 with cfg_len=0 or cfg_len > MAX_LEN:
  - Configuration unchanged; cfg_err=1 next cycle for one cycle.
  - History is not cleared, and a same-cycle valid sample is processed normally.
- len=1: every accepted bit equal to pattern[0] matches. In overlap=0 mode this still matches on consecutive bits, because FILL completes on each bit.
- A match pulse already scheduled when cfg_load is accepted is suppressed (cfg_load wins).
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined:
  - match_count port exists.
  - Increments by 1 in the same cycle outp rises, saturating at 2^CNT_W-1.
  - Cleared by rst and by an accepted cfg_load; not cleared by a rejected cfg_load.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset defaults, overlap: stream 1,0,1,0,1 (in_valid=1 each cycle) -> outp high exactly the cycle after the 3rd and 5th bits; match_count=2.
- Non-overlap: cfg_load pattern 101, len 3, overlap 0; stream 1,0,1,0,1,1,0,1 -> outp after bits 3 and 8 only; match_count=2.
- Qualifier gaps: pattern 11, len 2; sequence 1, invalid x3, 1 -> single match one cycle after the second valid 1; no outp in the gap cycles.
- Max length: cfg_load pattern 8'hA5, len 8; 7 valid bits then the completing bit -> no match during FILL; match after the 8th bit; next 8'hA5 match (overlap=1) only when the history aligns again.
- Illegal config: cfg_load with cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses twice; detection of the prior pattern continues uninterrupted.
- Mid-operation events:
  - cfg_load in the same cycle as a completing valid bit -> no outp, fill cleared.
  - rst asserted while outp is due -> outp=0, match_count=0, defaults restored.
